bin_to_bcd_stream: RTL

Streaming, parameterised binary-to-BCD converter using shift-and-add-3 (double dabble), one input bit per clock. It replaces repeated-addition conversion with a fixed-latency engine. It adds a valid/ready handshake on both sides, optional signed input, overflow detection with saturation, and a leading-zero blanking mask for display drivers. It sits between binary datapaths and the decimal display/output stages.

---
 rtl/bin_to_bcd_stream_pkg.sv | 20 ++
 rtl/bin_to_bcd_stream_if.sv | 26 ++
 rtl/bin_to_bcd_stream_dabble_digit.sv | 10 +
 rtl/bin_to_bcd_stream.sv | 104 ++++++++++
 4 files changed

// File: rtl/bin_to_bcd_stream_pkg.sv
// Shared types and constants for the streaming binary-to-BCD converter.
// Holds the digit type, the FSM state encoding and the counter width helper.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam bcd_digit_t BCD_NINE = 4'd9;

    // The counter must hold BIN_WIDTH itself, not just BIN_WIDTH-1.
    function automatic int cnt_width(input int bin_width);
        return $clog2(bin_width + 1);
    endfunction

endpackage

// File: rtl/bin_to_bcd_stream_if.sv
// Valid/ready input word channel and valid/ready BCD result channel.
// slave is the converter's view; master is the producer/consumer side.
interface bin_to_bcd_stream_if #(
    parameter int BIN_WIDTH  = 32,
    parameter int NUM_DIGITS = 10
);
    logic                    in_valid;
    logic                    in_ready;
    logic [BIN_WIDTH-1:0]    in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [4*NUM_DIGITS-1:0] out_digits;
    logic                    out_sign;
    logic                    out_overflow;
    logic [NUM_DIGITS-1:0]   out_blank;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_digits, out_sign, out_overflow, out_blank
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_digits, out_sign, out_overflow, out_blank
    );
endinterface

// File: rtl/bin_to_bcd_stream_dabble_digit.sv
// Double-dabble adjust for one BCD digit: values of 5 or more get +3.
// Purely combinational, no latency, no handshake.
module dabble_digit
    import bcd_pkg::*;
(
    input  bcd_digit_t digit,
    output bcd_digit_t adjusted
);
    assign adjusted = (digit >= 4'd5) ? bcd_digit_t'(digit + 4'd3) : digit;
endmodule

// File: rtl/bin_to_bcd_stream.sv
// Streaming binary-to-BCD converter, one bit per clock; result BIN_WIDTH cycles after accept.
// Single word in flight: in_ready low from accept until the result is taken by out_ready.
module bin_to_bcd_stream
    import bcd_pkg::*;
#(
    parameter int BIN_WIDTH  = 32,
    parameter int NUM_DIGITS = 10,
    parameter int SIGNED     = 0
) (
    input logic                clk,
    input logic                rst,
    bin_to_bcd_stream_if.slave bus
);
    localparam int CW = cnt_width(BIN_WIDTH);
    localparam int BW = 4 * NUM_DIGITS;

    state_t               state, next_state;
    logic [CW-1:0]        count;
    logic [BIN_WIDTH-1:0] shreg;
    logic [BW-1:0]        bcd;
    logic [BW-1:0]        adj;
    logic [BW-1:0]        digits;
    logic                 sign;
    logic                 overflow;
    logic                 neg;
    logic [BIN_WIDTH-1:0] mag;
    logic                 accept;

    assign accept = (state == IDLE) && bus.in_valid;
    assign neg    = (SIGNED != 0) && bus.in_data[BIN_WIDTH-1];
    // Two's-complement negate; the most negative value maps onto itself as unsigned.
    assign mag    = neg ? (~bus.in_data + 1'b1) : bus.in_data;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        dabble_digit u_adj (
            .digit    (bcd[4*g +: 4]),
            .adjusted (adj[4*g +: 4])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) next_state = SHIFT;
            end
            SHIFT: begin
                if (count == CW'(1)) next_state = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count    <= '0;
            shreg    <= '0;
            bcd      <= '0;
            sign     <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            count    <= CW'(BIN_WIDTH);
            shreg    <= mag;
            bcd      <= '0;
            sign     <= neg;
            overflow <= 1'b0;
        end else if (state == SHIFT) begin
            {bcd, shreg} <= {adj[BW-2:0], shreg, 1'b0};
            overflow     <= overflow | adj[BW-1];
            count        <= count - 1'b1;
        end
    end

    assign digits           = overflow ? {NUM_DIGITS{BCD_NINE}} : bcd;
    assign bus.out_digits   = digits;
    assign bus.out_sign     = sign;
    assign bus.out_overflow = overflow;

    // Blank runs downward from the top digit; the units digit is always shown.
    always_comb begin
        logic zero_run;
        zero_run      = 1'b1;
        bus.out_blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run         = zero_run & (digits[4*i +: 4] == 4'd0);
            bus.out_blank[i] = zero_run;
        end
    end
endmodule
